fmad_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared single-precision fused multiply-add unit `fmad`. It accepts operand triples from two independent requesters through valid/ready handshakes and grants them round-robin. It drives `fmad`'s one-cycle-early `req` and the following operand cycle, tracks every in-flight operation with a tag pipeline, and routes each result back to its owner. It also maintains a sticky exception-flag accumulator per requester.

---
 rtl/fmad_arb.sv | 138 +++++++++++++
 tb/tb_fmad_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fmad_arb.sv
// -----------------------------------------------------------------------------
// fmad_arb
//   Two-requester round-robin arbiter and sequencer for a shared single-precision
//   fused multiply-add unit (fmad). An accepted operand triple raises fma_req in
//   the accept cycle. The operands are registered and presented to fmad in the
//   following cycle. A tag pipeline of LAT stages follows each operation and
//   steers the fmad result back to the requester that issued it. A sticky flag
//   accumulator is kept for each requester.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   reqN_valid / reqN_ready    operand handshake, N = 0, 1 (ready is combinational)
//   reqN_x, reqN_y, reqN_z     operands; result = x*y + z
//   rspN_valid                 one-cycle result pulse for requester N
//   rspN_rslt, rspN_flag       result and exception flags (passthrough from fmad)
//   accN_flag, clrN_flag       sticky OR of rspN_flag, and its clear
//   fma_req                    to fmad.req, one cycle ahead of the operands
//   fma_x, fma_y, fma_z        registered operands to fmad
//   fma_rslt, fma_flag         result and flags from fmad
//   busy                       at least one operation in flight
// -----------------------------------------------------------------------------
module fmad_arb #(
   parameter int LAT = 4  // accept-to-response cycles (fmad latency + operand stage)
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_x,
   input  logic [31:0] req0_y,
   input  logic [31:0] req0_z,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_rslt,
   output logic [4:0]  rsp0_flag,
   output logic [4:0]  acc0_flag,
   input  logic        clr0_flag,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_x,
   input  logic [31:0] req1_y,
   input  logic [31:0] req1_z,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_rslt,
   output logic [4:0]  rsp1_flag,
   output logic [4:0]  acc1_flag,
   input  logic        clr1_flag,

   output logic        fma_req,
   output logic [31:0] fma_x,
   output logic [31:0] fma_y,
   output logic [31:0] fma_z,
   input  logic [31:0] fma_rslt,
   input  logic [4:0]  fma_flag,

   output logic        busy
);

   logic           gnt0;
   logic           gnt1;
   logic           accept;
   logic           pri;     // preferred requester when both are valid
   logic [LAT-1:0] tag_v;   // per-stage valid, stage LAT-1 is the response stage
   logic [LAT-1:0] tag_id;  // per-stage owner id
   logic [31:0]    op_x;
   logic [31:0]    op_y;
   logic [31:0]    op_z;
   logic [4:0]     acc0;
   logic [4:0]     acc1;

   // Grant: a lone valid wins. With both valid, pri wins. Reset blocks every
   // grant, so no operation can start in a reset cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (req0_valid && (!req1_valid || !pri)) gnt0 = 1'b1;
         else if (req1_valid)                     gnt1 = 1'b1;
      end
   end

   assign accept     = gnt0 | gnt1;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign fma_req    = accept;

   assign fma_x = op_x;
   assign fma_y = op_y;
   assign fma_z = op_z;

   // Responses leave the last tag stage. The result and flags come straight from fmad.
   assign rsp0_valid = tag_v[LAT-1] & ~tag_id[LAT-1];
   assign rsp1_valid = tag_v[LAT-1] &  tag_id[LAT-1];
   assign rsp0_rslt  = fma_rslt;
   assign rsp1_rslt  = fma_rslt;
   assign rsp0_flag  = fma_flag;
   assign rsp1_flag  = fma_flag;

   assign acc0_flag = acc0;
   assign acc1_flag = acc1;
   assign busy      = |tag_v;

   // Control state: priority pointer, operand stage, tag valids, accumulators.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments, so every register
      // in this block samples the values from before the edge.
      if (reset) begin
         pri   <= 1'b0;
         tag_v <= '0;
         op_x  <= '0;
         op_y  <= '0;
         op_z  <= '0;
         acc0  <= '0;
         acc1  <= '0;
      end else begin
         if (accept) begin
            pri  <= gnt0;  // the requester not just served becomes preferred
            op_x <= gnt1 ? req1_x : req0_x;
            op_y <= gnt1 ? req1_y : req0_y;
            op_z <= gnt1 ? req1_z : req0_z;
         end
         tag_v <= {tag_v[LAT-2:0], accept};
         // A clear in the pulse cycle keeps only the new response flags.
         acc0 <= (clr0_flag ? 5'd0 : acc0) | (rsp0_valid ? fma_flag : 5'd0);
         acc1 <= (clr1_flag ? 5'd0 : acc1) | (rsp1_valid ? fma_flag : 5'd0);
      end
   end

   // NOTE: owner ids have no reset. They matter only where the matching
   // tag_v bit is set, and tag_v is reset.
   always_ff @(posedge clk) begin
      tag_id <= {tag_id[LAT-2:0], gnt1};
   end

endmodule

// File: tb/tb_fmad_arb.sv
// -----------------------------------------------------------------------------
// tb_fmad_arb
//   Self-checking bench for fmad_arb. A behavioural stand-in for fmad samples
//   the operands one cycle after req and returns a table-driven result LAT
//   cycles after the accept. The stimulus pushes the expected responses into a
//   scoreboard. A monitor pops and compares on every response pulse.
// -----------------------------------------------------------------------------
module tb_fmad_arb;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, rsp0_valid, clr0_flag;
   logic [31:0] req0_x, req0_y, req0_z, rsp0_rslt;
   logic [4:0]  rsp0_flag, acc0_flag;
   logic        req1_valid, req1_ready, rsp1_valid, clr1_flag;
   logic [31:0] req1_x, req1_y, req1_z, rsp1_rslt;
   logic [4:0]  rsp1_flag, acc1_flag;
   logic        fma_req, busy;
   logic [31:0] fma_x, fma_y, fma_z, fma_rslt;
   logic [4:0]  fma_flag;

   always #5 clk = ~clk;

   fmad_arb #(.LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
      .rsp0_valid(rsp0_valid), .rsp0_rslt(rsp0_rslt), .rsp0_flag(rsp0_flag),
      .acc0_flag(acc0_flag), .clr0_flag(clr0_flag),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
      .rsp1_valid(rsp1_valid), .rsp1_rslt(rsp1_rslt), .rsp1_flag(rsp1_flag),
      .acc1_flag(acc1_flag), .clr1_flag(clr1_flag),
      .fma_req(fma_req), .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
      .fma_rslt(fma_rslt), .fma_flag(fma_flag),
      .busy(busy)
   );

   // Directed vectors: operands with hand-computed fp32 results and flags.
   typedef struct packed {
      logic [31:0] x, y, z, r;
      logic [4:0]  f;
   } vec_t;

   function automatic vec_t get_vec(input int i);
      case (i)
         0: return '{x:32'h3f800000, y:32'h40000000, z:32'h40400000, r:32'h40a00000, f:5'h00}; // 1*2+3=5
         1: return '{x:32'h40000000, y:32'h40000000, z:32'h00000000, r:32'h40800000, f:5'h00}; // 2*2+0=4
         2: return '{x:32'h3f800000, y:32'h3f800000, z:32'h3f800000, r:32'h40000000, f:5'h00}; // 1*1+1=2
         3: return '{x:32'h40400000, y:32'h40000000, z:32'h3f800000, r:32'h40e00000, f:5'h00}; // 3*2+1=7
         4: return '{x:32'h3f800000, y:32'h3f800000, z:32'h00000000, r:32'h3f800000, f:5'h00}; // 1*1+0=1
         5: return '{x:32'h7f800000, y:32'h00000000, z:32'h3f800000, r:32'hffc00000, f:5'h10}; // inf*0: invalid
         6: return '{x:32'h7f7fffff, y:32'h40000000, z:32'h00000000, r:32'h7f800000, f:5'h05}; // overflow+inexact
         default: return '{x:32'h3f800001, y:32'h3f800001, z:32'h00000000, r:32'h3f800002, f:5'h01}; // inexact
      endcase
   endfunction

   // fmad stand-in: sees req in cycle c, samples operands at the end of c+1,
   // and drives the result during c+LAT. It keeps running across a DUT reset.
   logic        req_q = 1'b0;
   logic [36:0] m_pipe [3];

   function automatic logic [36:0] fmad_model(input logic [31:0] x, y, z);
      vec_t v;
      for (int i = 0; i < 8; i++) begin
         v = get_vec(i);
         if (v.x == x && v.y == y && v.z == z) return {v.f, v.r};
      end
      return {5'h1f, 32'hbad0bad0};
   endfunction

   always @(posedge clk) begin
      req_q     <= fma_req;
      m_pipe[0] <= req_q ? fmad_model(fma_x, fma_y, fma_z) : {5'h1f, 32'hdeadbeef};
      m_pipe[1] <= m_pipe[0];
      m_pipe[2] <= m_pipe[1];
   end
   assign fma_rslt = m_pipe[2][31:0];
   assign fma_flag = m_pipe[2][36:32];

   // Checking infrastructure
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic        id;
      logic [31:0] r;
      logic [4:0]  f;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   // Monitor: every response pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
         exp_t e;
         check("rsp_onehot", 64'(rsp0_valid & rsp1_valid), 64'd0);
         if (sb.size() == 0) begin
            check("rsp_unexpected", 64'({rsp1_valid, rsp0_valid}), 64'd0);
         end else begin
            e = sb.pop_front();
            check("rsp_owner", 64'(rsp1_valid), 64'(e.id));
            check("rsp_cycle", 64'(cyc), 64'(e.cyc));
            check("rsp_rslt", 64'(e.id ? rsp1_rslt : rsp0_rslt), 64'(e.r));
            check("rsp_flag", 64'(e.id ? rsp1_flag : rsp0_flag), 64'(e.f));
         end
      end
   end

   // One stimulus cycle: drive the inputs and check the combinational grant
   // against the expected grant. Check the operands of the previous accept.
   // Push the expected response for the current accept.
   logic pend = 1'b0;
   vec_t pend_v;

   task automatic step(input logic v0, input logic v1, input int i0, input int i1,
                       input logic eg0, input logic eg1, input logic c0, input logic c1);
      vec_t a, b;
      exp_t e;
      a = get_vec(i0);
      b = get_vec(i1);
      req0_valid = v0; req0_x = a.x; req0_y = a.y; req0_z = a.z;
      req1_valid = v1; req1_x = b.x; req1_y = b.y; req1_z = b.z;
      clr0_flag  = c0; clr1_flag = c1;
      @(negedge clk);
      check("req0_ready", 64'(req0_ready), 64'(eg0));
      check("req1_ready", 64'(req1_ready), 64'(eg1));
      check("fma_req", 64'(fma_req), 64'(eg0 | eg1));
      if (pend) begin
         check("fma_x", 64'(fma_x), 64'(pend_v.x));
         check("fma_y", 64'(fma_y), 64'(pend_v.y));
         check("fma_z", 64'(fma_z), 64'(pend_v.z));
      end
      pend   = eg0 | eg1;
      pend_v = eg1 ? b : a;
      if (eg0 | eg1) begin
         e.id  = eg1;
         e.r   = pend_v.r;
         e.f   = pend_v.f;
         e.cyc = cyc + LAT;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Run idle cycles until all responses are back, with a fixed cycle bound.
   task automatic drain();
      for (int n = 0; n < 20 && (sb.size() != 0 || busy); n++) idle();
      check("drain_sb_empty", 64'(sb.size()), 64'd0);
      check("drain_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; clr0_flag = 1'b0; clr1_flag = 1'b0;
      req0_x = '0; req0_y = '0; req0_z = '0;
      req1_x = '0; req1_y = '0; req1_z = '0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state, with valids high to show that reset gates ready.
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
      check("rst_acc0", 64'(acc0_flag), 64'd0);
      check("rst_acc1", 64'(acc1_flag), 64'd0);
      check("rst_ops", {fma_x, fma_z}, 64'd0);
      check("rst_gate_ready", 64'({req1_ready, req0_ready}), 64'd0);
      check("rst_gate_req", 64'(fma_req), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Contention from reset: grants alternate 0,1,0,1,0,1.
      for (int k = 0; k < 6; k++)
         step(1'b1, 1'b1, k % 5, (k + 2) % 5, k % 2 == 0, k % 2 == 1, 1'b0, 1'b0);
      drain();

      // Single operation from requester 0: 1*2+3 = 5.
      step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      drain();

      // Exception accumulation on requester 1.
      step(1'b0, 1'b1, 0, 5, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 0, 6, 1'b0, 1'b1, 1'b0, 1'b0);
      drain();
      check("acc1_sticky", 64'(acc1_flag), 64'h15);
      check("acc0_clean", 64'(acc0_flag), 64'h00);

      // Clear, rebuild acc1 to 0x10, then clear in the pulse cycle of a 0x01 result.
      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("acc1_cleared", 64'(acc1_flag), 64'h00);
      step(1'b0, 1'b1, 0, 5, 1'b0, 1'b1, 1'b0, 1'b0);
      drain();
      check("acc1_invalid", 64'(acc1_flag), 64'h10);
      step(1'b0, 1'b1, 0, 7, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (LAT - 1) idle();
      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);  // pulse cycle
      check("acc1_clr_and_rsp", 64'(acc1_flag), 64'h01);
      drain();

      // Drop: after a grant to 0, requester 1 wins the tie, then requester 0 leaves.
      step(1'b1, 1'b0, 4, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4, 2, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      drain();

      // Reset with three operations in flight. Their responses must never appear.
      step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      sb.delete();
      reset = 1'b1;
      step(1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_acc1", 64'(acc1_flag), 64'd0);
      check("mid_rst_ops", {fma_x, fma_y}, 64'd0);
      repeat (LAT + 2) idle();
      step(1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
